// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

   localparam int DIV_WIDTH_DEF = 16;

   // Wide enough for any practical WIDTH; users truncate with a size cast.
   localparam logic [63:0] DIV_ZERO_QUOT = '1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract denom, set the new quotient bit.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] denom,
   output logic [WIDTH-1:0] r_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   // The shifted remainder can reach 2*denom-1, so the trial subtraction needs WIDTH+1 bits.
   always_comb begin
      shifted = {r, q[WIDTH-1]};
      diff    = shifted - {1'b0, denom};
      fits    = (shifted >= {1'b0, denom});
      r_next  = WIDTH'(fits ? diff : shifted);
      q_next  = {q[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             start,
   input  logic [WIDTH-1:0] numer,
   input  logic [WIDTH-1:0] denom,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remain,
   output logic             div_by_zero
);

   state_t           state;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] n_q;
   logic [CNT_W-1:0] cnt;
   logic             dz_q;

   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] numer_mag;
   logic [WIDTH-1:0] denom_mag;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r_q),
      .q      (q_q),
      .denom  (d_q),
      .r_next (r_nxt),
      .q_next (q_nxt)
   );

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic quot_neg_q;
   logic rem_neg_q;

   // Divide magnitudes; signs are reapplied in FIN so latency matches the unsigned build.
   always_comb begin
      numer_mag = numer[WIDTH-1] ? -numer : numer;
      denom_mag = denom[WIDTH-1] ? -denom : denom;
      quot_fix  = quot_neg_q ? -q_q : q_q;
      rem_fix   = rem_neg_q  ? -r_q : r_q;
   end
`else
   always_comb begin
      numer_mag = numer;
      denom_mag = denom;
      quot_fix  = q_q;
      rem_fix   = r_q;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remain      <= '0;
         div_by_zero <= 1'b0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         n_q         <= '0;
         cnt         <= '0;
         dz_q        <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         quot_neg_q  <= 1'b0;
         rem_neg_q   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  n_q  <= numer;
                  d_q  <= denom_mag;
                  dz_q <= (denom == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
                  quot_neg_q <= numer[WIDTH-1] ^ denom[WIDTH-1];
                  rem_neg_q  <= numer[WIDTH-1];
`endif
                  if (denom == '0) begin
                     state <= FIN;
                  end else begin
                     r_q   <= '0;
                     q_q   <= numer_mag;
                     cnt   <= CNT_W'(WIDTH);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               r_q <= r_nxt;
               q_q <= q_nxt;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= FIN;
            end
            FIN: begin
               done        <= 1'b1;
               busy        <= 1'b0;
               div_by_zero <= dz_q;
               quotient    <= dz_q ? WIDTH'(DIV_ZERO_QUOT) : quot_fix;
               remain      <= dz_q ? n_q : rem_fix;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results plus latency/handshake checks.
module tb_seq_divider;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic         CLK;
   logic         RESET_N;
   logic         start;
   logic [W-1:0] numer;
   logic [W-1:0] denom;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remain;
   logic         div_by_zero;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t last_exp;

   seq_divider #(.WIDTH(W)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .start       (start),
      .numer       (numer),
      .denom       (denom),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remain      (remain),
      .div_by_zero (div_by_zero)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
      exp_t e;
      if (d == '0) begin
         e.q  = '1;
         e.r  = n;
         e.dz = 1'b1;
      end else begin
         e.dz = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         if (n == 16'h8000 && d == 16'hFFFF) begin
            e.q = 16'h8000;
            e.r = '0;
         end else begin
            e.q = W'($signed(n) / $signed(d));
            e.r = W'($signed(n) % $signed(d));
         end
`else
         e.q = n / d;
         e.r = n % d;
`endif
      end
      return e;
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge CLK) begin
      if (RESET_N && done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done=1, required no result pending");
         end else begin
            exp_t e;
            e = sb.pop_front();
            last_exp = e;
            if ({quotient, remain, div_by_zero} !== {e.q, e.r, e.dz}) begin
               errors++;
               $display("FAIL result: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                        quotient, remain, div_by_zero, e.q, e.r, e.dz);
            end
         end
      end
   end

   task automatic wait_done(inout int lat);
      while (done !== 1'b1 && lat < 60) begin
         @(posedge CLK);
         #1;
         lat++;
      end
   endtask

   task automatic check_lat(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s_latency: got %0d edges, required %0d", name, got, req);
      end
   endtask

   // Caller is at posedge+1; returns at posedge+1 of the edge that raised done.
   task automatic do_div(input string name, input logic [W-1:0] n, input logic [W-1:0] d);
      int lat;
      numer = n;
      denom = d;
      start = 1'b1;
      sb.push_back(model(n, d));
      @(posedge CLK);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy: got busy=%b, required 1", name, busy);
      end
      lat = 0;
      wait_done(lat);
      check_lat(name, lat, (d == '0) ? 1 : W + 1);
   endtask

   task automatic test_reset;
      RESET_N = 1'b0;
      start   = 1'b0;
      numer   = '0;
      denom   = '0;
      #23;
      checks++;
      if ({busy, done, quotient, remain, div_by_zero} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b, required all 0",
                  busy, done, quotient, remain, div_by_zero);
      end
      RESET_N = 1'b1;
      @(posedge CLK);
      #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_basic;
      do_div("d1000_10", 16'd1000, 16'd10);
      do_div("d1007_17", 16'd1007, 16'd17);
      do_div("d65535_1", 16'd65535, 16'd1);
      do_div("d40000_40001", 16'd40000, 16'd40001);
      do_div("dmax_max", 16'hFFFF, 16'hFFFF);
      do_div("d0_7", 16'd0, 16'd7);
   endtask

   task automatic test_random;
      for (int i = 0; i < 10; i++) begin
         logic [W-1:0] n;
         logic [W-1:0] d;
         n = W'($urandom);
         d = W'($urandom) >> $urandom_range(0, 15);
         if (d == '0) d = 16'd3;
         do_div("random", n, d);
      end
   endtask

   task automatic test_div_zero;
      do_div("zero_5_0", 16'd5, 16'd0);
      do_div("zero_clear_9_3", 16'd9, 16'd3);
   endtask

   task automatic test_hold;
      exp_t held;
      do_div("hold_src", 16'd777, 16'd8);
      held = model(16'd777, 16'd8);
      repeat (6) begin
         numer = W'($urandom);
         denom = W'($urandom);
         @(posedge CLK);
         #1;
      end
      checks++;
      if ({quotient, remain, div_by_zero, done} !== {held.q, held.r, held.dz, 1'b0}) begin
         errors++;
         $display("FAIL hold: got q=%h r=%h dz=%b done=%b, required q=%h r=%h dz=%b done=0",
                  quotient, remain, div_by_zero, done, held.q, held.r, held.dz);
      end
   endtask

   task automatic test_ignore_busy;
      int lat;
      numer = 16'd1000;
      denom = 16'd10;
      start = 1'b1;
      sb.push_back(model(16'd1000, 16'd10));
      @(posedge CLK);
      #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge CLK);
         #1;
      end
      numer = 16'd50;
      denom = 16'd5;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      numer = 16'hDEAD;
      denom = 16'hBEEF;
      lat = 5;
      wait_done(lat);
      check_lat("ignore_busy", lat, W + 1);
      repeat (W + 4) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset_abort;
      numer = 16'd50;
      denom = 16'd5;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      repeat (7) begin
         @(posedge CLK);
         #1;
      end
      RESET_N = 1'b0;
      #2;
      checks++;
      if ({busy, done, quotient, remain, div_by_zero} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dz=%b, required all 0",
                  busy, done, quotient, remain, div_by_zero);
      end
      repeat (3) @(posedge CLK);
      #2;
      RESET_N = 1'b1;
      repeat (W + 4) begin
         @(posedge CLK);
         #1;
      end
      checks++;
      if ({busy, quotient} !== '0) begin
         errors++;
         $display("FAIL abort_no_resume: got busy=%b q=%h, required 0 0", busy, quotient);
      end
      do_div("after_abort_50_5", 16'd50, 16'd5);
   endtask

   task automatic test_back_to_back;
      int lat1;
      int lat2;
      numer = 16'd1000;
      denom = 16'd7;
      start = 1'b1;
      sb.push_back(model(16'd1000, 16'd7));
      @(posedge CLK);
      #1;
      numer = 16'd60000;
      denom = 16'd300;
      sb.push_back(model(16'd60000, 16'd300));
      lat1 = 0;
      wait_done(lat1);
      check_lat("b2b_first", lat1, W + 1);
      @(posedge CLK);
      #1;
      start = 1'b0;
      lat2 = 1;
      wait_done(lat2);
      check_lat("b2b_spacing", lat2, W + 2);
   endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
   task automatic test_signed;
      do_div("s_m7_2", 16'hFFF9, 16'd2);
      do_div("s_min_m1", 16'h8000, 16'hFFFF);
      do_div("s_100_m7", 16'd100, 16'hFFF9);
      do_div("s_m5_0", 16'hFFFB, 16'd0);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_random();
      test_hold();
      test_ignore_busy();
      test_reset_abort();
      test_back_to_back();
`ifdef SEQ_DIVIDER_SIGNED_EN
      test_signed();
`endif
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending_results: got %0d outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
